bsg_manycore_link_retimer: RTL

- Bidirectional retiming stage for the horizontal mesh links that join two adjacent compute subarrays inside a pod.
- Inserted between one subarray's east hor_link_sif port and the next subarray's west hor_link_sif port.
- Each direction is a fully registered 2-entry elastic buffer with valid/ready_and handshakes. This breaks long wires without losing throughput and preserves packet order.
- Lane 0 carries traffic west-to-east. Lane 1 carries traffic east-to-west.

---
 rtl/bsg_manycore_link_retimer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_link_retimer.sv
// bsg_manycore_link_retimer
//   Bidirectional retiming stage placed between the east hor_link_sif port of
//   one compute subarray and the west hor_link_sif port of its neighbour.
//   Every lane is an independent, fully registered 2-entry elastic buffer with
//   valid/ready_and handshakes. It breaks long wires at full throughput and
//   preserves packet order.
//   Lane 0 carries W->E traffic, lane 1 carries E->W traffic, and any further
//   lanes are extra virtual links.
//
// Parameters
//   width_p        payload width of one packet (must be set, > 0)
//   num_lanes_p    number of independent lanes
//   stats_width_p  width of each statistics counter (stats build only)
//
// Ports
//   clk_i          clock
//   reset_n_i      asynchronous, active-low reset
//   v_i            upstream valid, per lane
//   data_i         upstream payload, per lane
//   ready_and_o    stage can accept a packet (registered)
//   v_o            downstream valid (registered)
//   data_o         downstream payload (registered)
//   ready_and_i    downstream accepts
//   stall_cnt_o    cycles with v_i & ~ready_and_o, per lane (stats build only)
//   xfer_cnt_o     dequeued packets, per lane (stats build only)
//
// Optional feature
//   Define BSG_MANYCORE_LINK_RETIMER_STATS_EN to add saturating per-lane
//   stall/transfer counters and the stall_cnt_o/xfer_cnt_o ports. The
//   datapath behaves identically with or without it.

module bsg_manycore_link_retimer #(
  parameter int width_p       = 0,
  parameter int num_lanes_p   = 2,
  parameter int stats_width_p = 32
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_lanes_p-1:0]                v_i,
  input  logic [num_lanes_p-1:0][width_p-1:0]   data_i,
  output logic [num_lanes_p-1:0]                ready_and_o,
  output logic [num_lanes_p-1:0]                v_o,
  output logic [num_lanes_p-1:0][width_p-1:0]   data_o,
  input  logic [num_lanes_p-1:0]                ready_and_i
`ifdef BSG_MANYCORE_LINK_RETIMER_STATS_EN
  ,
  output logic [num_lanes_p-1:0][stats_width_p-1:0] stall_cnt_o,
  output logic [num_lanes_p-1:0][stats_width_p-1:0] xfer_cnt_o
`endif
);

  // Occupancy state doubles as the 2-bit entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_e;

  if (stats_width_p < 1) begin : g_bad_stats_width
    $error("bsg_manycore_link_retimer: stats_width_p must be at least 1");
  end

  for (genvar l = 0; l < num_lanes_p; l++) begin : g_lane

    lane_state_e        state_r, state_n;
    logic               init_r;
    logic               ready_r;
    logic               v_r;
    logic [width_p-1:0] head_r;
    logic [width_p-1:0] tail_r;
    logic               enq;
    logic               deq;

    assign enq = v_i[l] & ready_r & init_r;
    assign deq = v_r & ready_and_i[l];

    always_comb begin
      state_n = state_r;
      unique case (state_r)
        EMPTY: if (enq) state_n = ONE;
        ONE: begin
          if (enq & ~deq)      state_n = FULL;
          else if (~enq & deq) state_n = EMPTY;
        end
        FULL: if (deq) state_n = ONE;
        default: state_n = EMPTY;
      endcase
    end

    // ready/valid are registered from the next state so that neither depends
    // combinationally on v_i, data_i or ready_and_i.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_r <= EMPTY;
        init_r  <= 1'b0;
        ready_r <= 1'b0;
        v_r     <= 1'b0;
      end else begin
        state_r <= state_n;
        init_r  <= 1'b1;
        ready_r <= (state_n != FULL);
        v_r     <= (state_n != EMPTY);
      end
    end

    // Payload registers carry no reset; validity is tracked by state_r alone.
    always_ff @(posedge clk_i) begin
      unique case (state_r)
        EMPTY: if (enq) head_r <= data_i[l];
        ONE: begin
          if (enq & deq) head_r <= data_i[l];
          else if (enq)  tail_r <= data_i[l];
        end
        FULL: if (deq) head_r <= tail_r;
        default: ;
      endcase
    end

    assign ready_and_o[l] = ready_r;
    assign v_o[l]         = v_r;
    assign data_o[l]      = head_r;

`ifdef BSG_MANYCORE_LINK_RETIMER_STATS_EN
    logic [stats_width_p-1:0] stall_cnt_r;
    logic [stats_width_p-1:0] xfer_cnt_r;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        stall_cnt_r <= '0;
        xfer_cnt_r  <= '0;
      end else begin
        if (v_i[l] & ~ready_r & (stall_cnt_r != '1))
          stall_cnt_r <= stall_cnt_r + 1'b1;
        if (deq & (xfer_cnt_r != '1))
          xfer_cnt_r <= xfer_cnt_r + 1'b1;
      end
    end

    assign stall_cnt_o[l] = stall_cnt_r;
    assign xfer_cnt_o[l]  = xfer_cnt_r;
`endif

`ifndef SYNTHESIS
    a_data_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      enq |-> !$isunknown(data_i[l]));
    a_count_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      state_r inside {EMPTY, ONE, FULL});
`endif

  end

endmodule
